// File: rtl/fir_mac_seq_if.sv
// Sample/coefficient/result bus of the sequential FIR MAC.
// The master drives samples and coefficient writes; the slave returns results.
interface fir_mac_seq_if #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int TAPS = 16
);
  localparam int AIW = $clog2(TAPS);

  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  in_data;
  logic                  coef_we;
  logic [AIW-1:0]        coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic                  out_valid;
  logic signed [DW-1:0]  out_data;
  logic                  busy;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Single-multiplier FIR: one tap per cycle over a TAPS-deep delay line,
// then an arithmetic right shift and saturation to the sample width.
module fir_mac_seq #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 16,
  parameter int SHIFT = 11
) (
  input  logic           clk,
  input  logic           rst,
  fir_mac_seq_if.slave   bus
);
  localparam int AIW = $clog2(TAPS);
  localparam int PW  = DW + CW;
  localparam int AW  = DW + CW + AIW;
  localparam logic [AIW-1:0] LAST   = AIW'(TAPS - 1);
  localparam logic [AIW:0]   TAPS_C = (AIW + 1)'(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic signed [AW-1:0]      acc_q, acc_d;
  logic [AIW-1:0]            cnt_q, cnt_d;
  logic [TAPS-1:0][DW-1:0]   dly_q, dly_d;
  logic [TAPS-1:0][CW-1:0]   coef_q, coef_d;
  logic                      out_valid_q, out_valid_d;
  logic [DW-1:0]             out_data_q, out_data_d;

  // Current tap product, both operands sign-extended to full product width
  logic [CW-1:0]             c_sel;
  logic [DW-1:0]             d_sel;
  logic signed [PW-1:0]      c_ext, d_ext, prod;
  logic signed [AW-1:0]      prod_ext;

  assign c_sel    = coef_q[cnt_q];
  assign d_sel    = dly_q[cnt_q];
  assign c_ext    = {{DW{c_sel[CW-1]}}, c_sel};
  assign d_ext    = {{CW{d_sel[DW-1]}}, d_sel};
  assign prod     = c_ext * d_ext;
  assign prod_ext = {{AIW{prod[PW-1]}}, prod};

  // Floor shift, then clamp when the upper bits are not pure sign extension
  logic signed [AW-1:0]      acc_sh;
  logic                      fits;
  logic [DW-1:0]             sat;

  assign acc_sh = acc_q >>> SHIFT;
  assign fits   = (&acc_sh[AW-1:DW-1]) | ~(|acc_sh[AW-1:DW-1]);
  assign sat    = fits         ? acc_sh[DW-1:0] :
                  acc_sh[AW-1] ? {1'b1, {(DW-1){1'b0}}} :
                                 {1'b0, {(DW-1){1'b1}}};

  logic addr_ok;
  assign addr_ok = ({1'b0, bus.coef_addr} < TAPS_C);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;
    coef_d      = coef_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.coef_we && addr_ok) coef_d[bus.coef_addr] = bus.coef_data;
        if (bus.in_valid) begin
          dly_d   = {dly_q[TAPS-2:0], bus.in_data};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        out_data_d  = sat;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      dly_q       <= '0;
      coef_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      coef_q      <= coef_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_MAC) || (state_q == S_DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: vector table, hand-built corner sequences and random
// traffic, all scored against a sum-of-products reference with timing tracking.
module tb_fir_mac_seq;
  localparam int DW = 16, CW = 16, TAPS = 16, SHIFT = 11;
  localparam int LAT = TAPS + 1, PERIOD = TAPS + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_mac_seq_if #(.DW(DW), .CW(CW), .TAPS(TAPS)) bus();
  fir_mac_seq #(.DW(DW), .CW(CW), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: coefficient table, sample history, time-to-idle counter
  longint m_coef[TAPS];
  longint m_hist[TAPS];
  int     m_busy = 0;
  longint edge_n = 0;
  longint last_acc = 0, acc_gap = 0;
  bit     acc_seen = 0;
  longint exp_q[$], due_q[$], out_log[$];
  longint last_out = 0;

  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += m_coef[k] * m_hist[k];
    s = s >>> SHIFT;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    edge_n++;
    acc_seen = 0;
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin m_coef[k] = 0; m_hist[k] = 0; end
      m_busy = 0;
      last_out = 0;
      exp_q.delete();
      due_q.delete();
    end else if (m_busy == 0) begin
      if (bus.coef_we && int'(bus.coef_addr) < TAPS) m_coef[bus.coef_addr] = bus.coef_data;
      if (bus.in_valid) begin
        for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = bus.in_data;
        exp_q.push_back(model_out());
        due_q.push_back(edge_n + LAT);
        acc_gap  = edge_n - last_acc;
        last_acc = edge_n;
        acc_seen = 1;
        m_busy   = PERIOD - 1;
      end
    end else begin
      m_busy--;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", bus.in_ready, m_busy == 0);
      chk("busy", bus.busy, m_busy != 0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          chk("out_data", bus.out_data, exp_q.pop_front());
          chk("latency", edge_n, due_q.pop_front());
        end
        last_out = bus.out_data;
        out_log.push_back(last_out);
      end else begin
        chk("out_hold", bus.out_data, last_out);
        if (due_q.size() > 0 && edge_n > due_q[0]) begin
          chk("missing_out_valid", 0, 1);
          void'(due_q.pop_front());
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wcoef(input int a, input int v);
    @(negedge clk);
    bus.coef_we = 1'b1; bus.coef_addr = 4'(a); bus.coef_data = 16'(v);
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!acc_seen && n < 60);
    if (!acc_seen) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output longint res);
    int n = 0;
    while (!bus.out_valid && n < 60) begin @(negedge clk); n++; end
    if (!bus.out_valid) chk("result_timeout", 0, 1);
    res = bus.out_data;
  endtask

  // Offer a sample; while busy keep in_valid high with junk that must be ignored
  task automatic send(input int x, output longint res);
    logic [31:0] r;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'(x);
    wait_accept();
    r = $urandom;
    bus.in_data = r[15:0];
    wait_out(res);
    bus.in_valid = 1'b0;
  endtask

  typedef struct { int c0; int x; int exp; } vec_t;
  vec_t tv[9];

  initial begin
    longint res;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    tv[0] = '{2048, 1000, 1000};
    tv[1] = '{1024, 3, 1};
    tv[2] = '{1024, -3, -2};
    tv[3] = '{-2048, 1000, -1000};
    tv[4] = '{2048, -1, -1};
    tv[5] = '{1024, 1, 0};
    tv[6] = '{32767, 32767, 32767};
    tv[7] = '{-32768, 32767, -32768};
    tv[8] = '{2048, -32768, -32768};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_data", bus.out_data, 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      wcoef(0, tv[i].c0);
      send(tv[i].x, res);
      chk($sformatf("vec%0d", i), res, tv[i].exp);
    end

    // Sign/rounding pair on one running history
    do_reset();
    wcoef(0, 1024);
    send(3, res);  chk("round_pos", res, 1);
    send(-3, res); chk("round_neg", res, -2);

    // Saturation with every tap at full scale
    do_reset();
    for (int k = 0; k < TAPS; k++) wcoef(k, 32767);
    for (int i = 0; i < TAPS; i++) send(32767, res);
    chk("sat_pos", res, 32767);
    for (int i = 0; i < TAPS; i++) send(-32768, res);
    chk("sat_neg", res, -32768);

    // Back-to-back with in_valid held high: running sums every PERIOD edges
    do_reset();
    for (int k = 0; k < TAPS; k++) wcoef(k, 2048);
    out_log.delete();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'(1);
    for (int n = 1; n <= 4; n++) begin
      wait_accept();
      if (n > 1) chk("b2b_gap", acc_gap, PERIOD);
      bus.in_data = 16'(n + 1);
      if (n == 4) bus.in_valid = 1'b0;
    end
    repeat (25) @(negedge clk);
    chk("b2b_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      chk("b2b_out0", out_log[0], 1);
      chk("b2b_out1", out_log[1], 3);
      chk("b2b_out2", out_log[2], 6);
      chk("b2b_out3", out_log[3], 10);
    end

    // Reset in the middle of accumulation discards the result and coefficients
    do_reset();
    wcoef(0, 2048);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'(1000);
    wait_accept();
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", bus.in_ready, 1);
    out_log.delete();
    repeat (30) @(negedge clk);
    chk("midrst_no_out", out_log.size(), 0);
    send(1000, res);
    chk("midrst_coef_cleared", res, 0);

    // Reset wins over a simultaneous sample and coefficient write
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'(1000);
    bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_data = 16'(2048);
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0; bus.coef_we = 1'b0;
    chk("rstprio_idle", bus.busy, 0);
    send(1000, res);
    chk("rstprio_result", res, 0);

    // Coefficient write while busy is dropped
    do_reset();
    wcoef(0, 2048);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'(500);
    wait_accept();
    bus.in_valid = 1'b0;
    bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_data = 16'(1024);
    wait_out(res);
    bus.coef_we = 1'b0;
    chk("drop_cur", res, 500);
    send(700, res);
    chk("drop_next", res, 700);

    // Accept and coefficient write on the same edge: new coefficient applies
    do_reset();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'(1000);
    bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_data = 16'(2048);
    wait_accept();
    bus.in_valid = 1'b0; bus.coef_we = 1'b0;
    wait_out(res);
    chk("same_edge_write", res, 1000);

    // Random coefficients and samples, scored by the reference
    do_reset();
    for (int k = 0; k < TAPS; k++) wcoef(k, int'($urandom_range(0, 8191)) - 4096);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        wcoef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 8191)) - 4096);
      send(int'($urandom_range(0, 65535)) - 32768, res);
    end

    repeat (25) @(negedge clk);
    chk("pending_results", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
